// File: rtl/data_memory_responder_if.sv
// Line-request bus between the dcache (master) and the off-chip data memory
// model (slave): one 256-bit line per request, completion signalled by ack.
interface data_memory_responder_if;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         enable_i;
   logic         write_i;
   logic         ack_o;
   logic [255:0] data_o;

   modport master (
      output addr_i,
      output data_i,
      output enable_i,
      output write_i,
      input  ack_o,
      input  data_o
   );

   modport slave (
      input  addr_i,
      input  data_i,
      input  enable_i,
      input  write_i,
      output ack_o,
      output data_o
   );
endinterface

// File: rtl/data_memory_responder.sv
// Off-chip data memory model answering 256-bit line requests after a fixed
// latency. One request in flight; the request is latched on acceptance so the
// initiator's bus may change freely while the access is pending.
// Cycle k is the clock period ending at rising edge k. A request accepted at
// edge N is acknowledged in cycle N+LATENCY, i.e. ack_o rises after edge
// N+LATENCY-1 and the write commits at edge N+LATENCY.
module data_memory_responder #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned IDX_W   = 9
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   data_memory_responder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_e;

   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [255:0]       wdata_q, wdata_d;
   logic               write_q, write_d;
   logic               ack_q, ack_d;
   logic [255:0]       rdata_q, rdata_d;
   logic [IDX_W-1:0]   req_idx_s;

   // Storage is deliberately not reset; the testbench preloads it directly.
   logic [255:0]       mem_q [DEPTH];

   // Only the line-index bits of the byte address matter; the rest wrap.
   logic               unused_addr_s;
   assign unused_addr_s = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};
   assign req_idx_s     = bus.addr_i[IDX_W+4:5];

   // Next-state, request latching and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      write_d = write_q;
      ack_d   = 1'b0;
      rdata_d = 256'd0;
      case (state_q)
         S_IDLE: begin
            if (bus.enable_i) begin
               idx_d   = req_idx_s;
               wdata_d = bus.data_i;
               write_d = bus.write_i;
               cnt_d   = CNT_INIT;
               if (CNT_INIT == 8'd0) begin
                  // Single-cycle latency: acknowledge in the very next cycle.
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  if (bus.write_i) begin
                     rdata_d = 256'd0;
                  end else begin
                     rdata_d = mem_q[req_idx_s];
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 8'd1) begin
               // Counter reaches zero on this edge: present the response.
               cnt_d   = 8'd0;
               state_d = S_ACK;
               ack_d   = 1'b1;
               if (write_q) begin
                  rdata_d = 256'd0;
               end else begin
                  rdata_d = mem_q[idx_q];
               end
            end else begin
               cnt_d   = cnt_q - 8'd1;
               state_d = S_WAIT;
            end
         end
         S_ACK: begin
            // enable_i is not sampled here; a held request waits for IDLE.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Control and output registers; reset aborts any pending request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         wdata_q <= 256'd0;
         write_q <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= 256'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   // Commit a latched write at the edge that ends the ACK cycle.
   always_ff @(posedge clk_i) begin
      if ((state_q == S_ACK) && write_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign bus.ack_o  = ack_q;
   assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed testbench for data_memory_responder: one instance at LATENCY 10,
// one at LATENCY 1. Inputs change on falling edges, outputs are sampled on
// falling edges; cycle k is the period ending at rising edge k after the
// accepting edge 0.
module tb_data_memory_responder;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   data_memory_responder_if bus10 ();
   data_memory_responder_if bus1 ();

   data_memory_responder #(.LATENCY(10), .DEPTH(512), .IDX_W(9)) dut10 (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus10.slave)
   );

   data_memory_responder #(.LATENCY(1), .DEPTH(512), .IDX_W(9)) dut1 (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request on the LATENCY-10 bus and report when ack appeared,
   // the line returned, and the outputs in the cycle after the ack.
   task automatic do_req(input logic [31:0] addr, input logic [255:0] wdata,
                         input logic wr, output int ack_cyc,
                         output logic [255:0] rdata, output logic next_ack,
                         output logic [255:0] next_data);
      ack_cyc   = 0;
      rdata     = 256'd0;
      @(negedge clk);
      bus10.addr_i   = addr;
      bus10.data_i   = wdata;
      bus10.write_i  = wr;
      bus10.enable_i = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus10.ack_o === 1'b1) begin
            ack_cyc = k;
            rdata   = bus10.data_o;
            break;
         end
      end
      bus10.enable_i = 1'b0;
      bus10.write_i  = 1'b0;
      @(negedge clk);
      next_ack  = bus10.ack_o;
      next_data = bus10.data_o;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus10.ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ack got %b expected 0", bus10.ack_o);
      end
      n_checks++;
      if (bus10.data_o !== 256'd0) begin
         n_fail++;
         $display("FAIL reset_data got %h expected 0", bus10.data_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      int cyc;
      logic [255:0] rd, nd;
      logic na;
      dut10.mem_q[4] = {8{32'hDEADBEEF}};
      do_req(32'h0000_0080, 256'd0, 1'b0, cyc, rd, na, nd);
      n_checks++;
      if (cyc !== 10) begin
         n_fail++;
         $display("FAIL read_latency got %0d expected 10", cyc);
      end
      n_checks++;
      if (rd !== {8{32'hDEADBEEF}}) begin
         n_fail++;
         $display("FAIL read_data got %h expected %h", rd, {8{32'hDEADBEEF}});
      end
      n_checks++;
      if (na !== 1'b0 || nd !== 256'd0) begin
         n_fail++;
         $display("FAIL read_after_ack got ack=%b data=%h expected 0/0", na, nd);
      end
   endtask

   task automatic test_write_read();
      int cyc;
      logic [255:0] rd, nd;
      logic na;
      do_req(32'h0000_0400, 256'h1234, 1'b1, cyc, rd, na, nd);
      n_checks++;
      if (cyc !== 10 || rd !== 256'd0) begin
         n_fail++;
         $display("FAIL write_ack got cyc=%0d data=%h expected 10/0", cyc, rd);
      end
      n_checks++;
      if (dut10.mem_q[32] !== 256'h1234) begin
         n_fail++;
         $display("FAIL write_commit got %h expected 1234", dut10.mem_q[32]);
      end
      do_req(32'h0000_0400, 256'd0, 1'b0, cyc, rd, na, nd);
      n_checks++;
      if (cyc !== 10 || rd !== 256'h1234) begin
         n_fail++;
         $display("FAIL raw_read got cyc=%0d data=%h expected 10/1234", cyc, rd);
      end
   endtask

   task automatic test_wrap();
      int cyc;
      logic [255:0] rd, nd;
      logic na;
      dut10.mem_q[0] = 256'd0;
      do_req(32'h0000_401F, 256'hA5, 1'b1, cyc, rd, na, nd);
      n_checks++;
      if (dut10.mem_q[0] !== 256'hA5) begin
         n_fail++;
         $display("FAIL wrap_commit got %h expected a5", dut10.mem_q[0]);
      end
      do_req(32'h0000_0000, 256'd0, 1'b0, cyc, rd, na, nd);
      n_checks++;
      if (rd !== 256'hA5) begin
         n_fail++;
         $display("FAIL wrap_read got %h expected a5", rd);
      end
   endtask

   task automatic test_latched();
      int cyc;
      logic [255:0] rd;
      cyc = 0;
      rd  = 256'd0;
      dut10.mem_q[2] = 256'hC0FFEE02;
      dut10.mem_q[7] = 256'h77;
      @(negedge clk);
      bus10.addr_i   = 32'h0000_0040;
      bus10.data_i   = 256'd0;
      bus10.write_i  = 1'b0;
      bus10.enable_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus10.addr_i  = 32'h0000_00E0;
      bus10.write_i = 1'b1;
      bus10.data_i  = 256'hBAD;
      if (bus10.ack_o === 1'b1) begin
         cyc = 1;
         rd  = bus10.data_o;
      end else begin
         for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (bus10.ack_o === 1'b1) begin
               cyc = k;
               rd  = bus10.data_o;
               break;
            end
         end
      end
      bus10.enable_i = 1'b0;
      bus10.write_i  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cyc !== 10 || rd !== 256'hC0FFEE02) begin
         n_fail++;
         $display("FAIL latched_read got cyc=%0d data=%h expected 10/c0ffee02", cyc, rd);
      end
      n_checks++;
      if (dut10.mem_q[7] !== 256'h77) begin
         n_fail++;
         $display("FAIL latched_no_write got %h expected 77", dut10.mem_q[7]);
      end
   endtask

   task automatic test_reset_mid();
      int acks;
      int cyc;
      logic [255:0] rd, nd;
      logic na;
      acks = 0;
      dut10.mem_q[5] = 256'h55;
      @(negedge clk);
      bus10.addr_i   = 32'h0000_00A0;
      bus10.data_i   = 256'hEE;
      bus10.write_i  = 1'b1;
      bus10.enable_i = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      bus10.enable_i = 1'b0;
      bus10.write_i  = 1'b0;
      #1;
      n_checks++;
      if (bus10.ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_ack got %b expected 0", bus10.ack_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus10.ack_o === 1'b1) acks++;
      end
      n_checks++;
      if (acks !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_ack got %0d acks expected 0", acks);
      end
      n_checks++;
      if (dut10.mem_q[5] !== 256'h55) begin
         n_fail++;
         $display("FAIL rst_mid_no_write got %h expected 55", dut10.mem_q[5]);
      end
      do_req(32'h0000_00A0, 256'd0, 1'b0, cyc, rd, na, nd);
      n_checks++;
      if (cyc !== 10 || rd !== 256'h55) begin
         n_fail++;
         $display("FAIL rst_mid_recover got cyc=%0d data=%h expected 10/55", cyc, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_ack [1:4];
      logic obs_ack [1:4];
      logic [255:0] obs_data [1:4];
      exp_ack[1] = 1'b1;
      exp_ack[2] = 1'b0;
      exp_ack[3] = 1'b1;
      exp_ack[4] = 1'b0;
      dut1.mem_q[3] = 256'h31;
      @(negedge clk);
      bus1.addr_i   = 32'h0000_0060;
      bus1.data_i   = 256'd0;
      bus1.write_i  = 1'b0;
      bus1.enable_i = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         obs_ack[k]  = bus1.ack_o;
         obs_data[k] = bus1.data_o;
         if (k == 3) bus1.enable_i = 1'b0;
      end
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (obs_ack[k] !== exp_ack[k]) begin
            n_fail++;
            $display("FAIL lat1_ack_cycle%0d got %b expected %b", k, obs_ack[k], exp_ack[k]);
         end
      end
      n_checks++;
      if (obs_data[1] !== 256'h31 || obs_data[3] !== 256'h31) begin
         n_fail++;
         $display("FAIL lat1_data got %h/%h expected 31/31", obs_data[1], obs_data[3]);
      end
      n_checks++;
      if (obs_data[2] !== 256'd0) begin
         n_fail++;
         $display("FAIL lat1_data_idle got %h expected 0", obs_data[2]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus10.addr_i = 32'd0; bus10.data_i = 256'd0; bus10.enable_i = 1'b0; bus10.write_i = 1'b0;
      bus1.addr_i  = 32'd0; bus1.data_i  = 256'd0; bus1.enable_i  = 1'b0; bus1.write_i  = 1'b0;
      test_reset();
      test_read();
      test_write_read();
      test_wrap();
      test_latched();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
